// File: rtl/ifetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_unit_pkg
// Purpose  : Shared opcode constants, fetch FSM encoding and queue entry
//            layout for the instruction fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
package ifetch_unit_pkg;

  // RV32I major opcodes the static predictor cares about
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Fetch FSM: IDLE = no request in flight, WAIT = request in flight,
  // DROP = request in flight whose response must be thrown away
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  // One instruction queue slot
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        taken;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/ifetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_unit_if
// Purpose  : Icache request/response and decoder hand-off signals of the
//            fetch unit. master = fetch unit, slave = icache/decoder side.
// Revision : 1.0 - initial release
// ============================================================================
interface ifetch_unit_if;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_resp_valid;
  logic [31:0] icache_inst;
  logic        issue_stall;
  logic        inst_rdy;
  logic [31:0] inst;
  logic [31:0] inst_PC;
  logic        inst_is_Jump;

  modport master (
    output icache_req, icache_addr, inst_rdy, inst, inst_PC, inst_is_Jump,
    input  icache_resp_valid, icache_inst, issue_stall
  );

  modport slave (
    input  icache_req, icache_addr, inst_rdy, inst, inst_PC, inst_is_Jump,
    output icache_resp_valid, icache_inst, issue_stall
  );
endinterface
`default_nettype wire

// File: rtl/ifetch_unit_predecode.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_predecode
// Purpose  : Static next-PC prediction. JAL and backward conditional
//            branches are predicted taken; everything else (JALR included)
//            falls through to pc+4.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_predecode
  import ifetch_unit_pkg::*;
(
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  output logic [31:0] o_next_pc,
  output logic        o_taken
);

  logic [31:0] w_j_imm;
  logic [31:0] w_b_imm;

  // Decode immediates and select the predicted successor PC
  always_comb begin
    w_j_imm   = {{12{i_inst[31]}}, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
    w_b_imm   = {{20{i_inst[31]}}, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    o_next_pc = i_pc + 32'd4;
    o_taken   = 1'b0;
    case (i_inst[6:0])
      OPC_JAL: begin
        o_next_pc = i_pc + w_j_imm;
        o_taken   = 1'b1;
      end
      OPC_BRANCH: begin
        // sign bit set means negative offset, i.e. a loop back-edge
        if (i_inst[31]) begin
          o_next_pc = i_pc + w_b_imm;
          o_taken   = 1'b1;
        end
      end
      OPC_JALR: begin
        // target is register-relative, cannot be predicted here
        o_next_pc = i_pc + 32'd4;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_unit
// Purpose  : Front-end fetch stage. Issues one icache request at a time,
//            predicts the next PC, buffers fetched words in an in-order
//            queue and presents the head to the decoder. Rollback flushes
//            the queue and redirects fetch.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int          QUEUE_LOG = 4,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rdy,
  input  logic          rollback,
  input  logic [31:0]   rollback_pc,
  ifetch_unit_if.master bus
);

  localparam int                 DEPTH     = 1 << QUEUE_LOG;
  localparam logic [QUEUE_LOG:0] C_DEPTH   = {1'b1, {QUEUE_LOG{1'b0}}};
  localparam logic [QUEUE_LOG:0] C_CNT_ONE = {{QUEUE_LOG{1'b0}}, 1'b1};
  localparam logic [QUEUE_LOG-1:0] C_PTR_ONE = {{(QUEUE_LOG-1){1'b0}}, 1'b1};

  fetch_state_e         state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [QUEUE_LOG-1:0] head_q, head_d;
  logic [QUEUE_LOG-1:0] tail_q, tail_d;
  logic [QUEUE_LOG:0]   count_q, count_d;
  logic                 req_q, req_d;
  logic [31:0]          addr_q, addr_d;
  fetch_entry_t         queue_q [DEPTH];
  fetch_entry_t         entry_d;
  fetch_entry_t         w_head;

  logic                 w_push;
  logic                 w_pop;
  logic [31:0]          w_next_pc;
  logic                 w_taken;
  logic [QUEUE_LOG:0]   w_count_after;

  ifetch_predecode u_predecode (
    .i_inst    (bus.icache_inst),
    .i_pc      (pc_q),
    .o_next_pc (w_next_pc),
    .o_taken   (w_taken)
  );

  assign entry_d       = {bus.icache_inst, pc_q, w_taken};
  assign w_head        = queue_q[head_q];
  assign w_pop         = (count_q != '0) && !bus.issue_stall && !rollback && rdy;
  // occupancy after accepting this cycle's response and any pop
  assign w_count_after = count_q + C_CNT_ONE - {{QUEUE_LOG{1'b0}}, w_pop};

  assign bus.inst_rdy     = w_pop;
  assign bus.inst         = w_head.inst;
  assign bus.inst_PC      = w_head.pc;
  assign bus.inst_is_Jump = w_head.taken;
  assign bus.icache_req   = req_q;
  assign bus.icache_addr  = addr_q;

  // Fetch FSM next state, pc, pointers and request generation
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    req_d   = req_q;
    addr_d  = addr_q;
    w_push  = 1'b0;
    if (rdy) begin
      req_d = 1'b0;
      if (rollback) begin
        pc_d    = rollback_pc;
        head_d  = tail_q;
        count_d = '0;
        case (state_q)
          // a response arriving with the rollback retires the in-flight
          // request, so nothing is left to drop
          ST_WAIT, ST_DROP: state_d = bus.icache_resp_valid ? ST_IDLE : ST_DROP;
          default:          state_d = ST_IDLE;
        endcase
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (count_q < C_DEPTH) begin
              req_d   = 1'b1;
              addr_d  = pc_q;
              state_d = ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (bus.icache_resp_valid) begin
              w_push = 1'b1;
              pc_d   = w_next_pc;
              tail_d = tail_q + C_PTR_ONE;
              if (w_count_after < C_DEPTH) begin
                req_d  = 1'b1;
                addr_d = w_next_pc;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end
          ST_DROP: begin
            if (bus.icache_resp_valid) state_d = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
        if (w_pop) head_d = head_q + C_PTR_ONE;
        count_d = count_q + {{QUEUE_LOG{1'b0}}, w_push} - {{QUEUE_LOG{1'b0}}, w_pop};
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  // Instruction queue storage, written at the tail on each accepted response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) queue_q[i] <= '0;
    end else if (w_push) begin
      queue_q[tail_q] <= entry_d;
    end
  end

endmodule
`default_nettype wire
